// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU types for the TLB slice.
//   pte_t             - Sv39-style page table entry as returned by the PTW
//   pg_level_e        - page size of a translation (kilo / mega / giga)
//   param_tlb_entry_t - one TLB entry (ASID is stored beside it, as its
//                       width is a TLB parameter)
//   vpn_match()       - VPN compare at a given page level
package mmu_pkg;

  localparam int VPN_SIZE      = 27;
  localparam int PPN_SIZE      = 44;
  localparam int PAGE_LVL_BITS = 9;

  typedef enum logic [1:0] {
    KILO_PAGE = 2'd0,
    MEGA_PAGE = 2'd1,
    GIGA_PAGE = 2'd2
  } pg_level_e;

  typedef struct packed {
    logic [9:0]          reserved;
    logic [PPN_SIZE-1:0] ppn;
    logic [1:0]          rsw;
    logic                d;
    logic                a;
    logic                g;
    logic                u;
    logic                x;
    logic                w;
    logic                r;
    logic                v;
  } pte_t;

  // nempty marks an occupied slot; valid=0 marks a slot holding a walk error
  // that must fault once and then be dropped.
  typedef struct packed {
    logic                nempty;
    logic                valid;
    pg_level_e           level;
    logic [VPN_SIZE-1:0] vpn;
    logic [PPN_SIZE-1:0] ppn;
    logic                d;
    logic                g;
    logic                u;
    logic                x;
    logic                w;
    logic                r;
  } param_tlb_entry_t;

  function automatic logic vpn_match(input pg_level_e lvl,
                                     input logic [VPN_SIZE-1:0] a,
                                     input logic [VPN_SIZE-1:0] b);
    case (lvl)
      GIGA_PAGE: return a[26:18] == b[26:18];
      MEGA_PAGE: return a[26:9]  == b[26:9];
      default:   return a == b;
    endcase
  endfunction

endpackage

// File: rtl/param_tlb_plru.sv
// param_tlb_plru: tree pseudo-LRU replacement for ENTRIES ways.
//   clk_i, rstn_i : clock, async active-low reset (tree cleared)
//   touch_i       : mark touch_idx_i as most recently used
//   touch_idx_i   : way that was used
//   victim_o      : way the tree currently points at
// Tree nodes are stored heap-ordered (children of n at 2n+1, 2n+2); each bit
// points toward the less recently used half.
module param_tlb_plru #(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] victim_o
);

  logic [ENTRIES-2:0] tree_q, tree_d;
  int                 t_node, v_node;

  always_comb begin
    tree_d = tree_q;
    t_node = 0;
    if (touch_i) begin
      for (int l = 0; l < IDX_W; l++) begin
        tree_d[IDX_W'(t_node)] = ~touch_idx_i[IDX_W-1-l];
        t_node = 2 * t_node + 1 + int'(touch_idx_i[IDX_W-1-l]);
      end
    end
  end

  always_comb begin
    victim_o = '0;
    v_node   = 0;
    for (int l = 0; l < IDX_W; l++) begin
      victim_o[IDX_W-1-l] = tree_q[IDX_W'(v_node)];
      v_node = 2 * v_node + 1 + int'(tree_q[IDX_W'(v_node)]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/param_tlb.sv
// param_tlb: fully associative TLB with combinational lookup and a single
// outstanding page-table walk.
//   request : req_valid_i/vpn/asid/store/fetch/passthrough -> ready_o, miss_o,
//             ppn_o, xcpt_ld_o/st_o/if_o (all combinational)
//   status  : vm_enable_i, priv_lvl_i (0 = user), sum_i, mxr_i
//   PTW     : ptw_req_* out with ptw_ready_i; ptw_resp_* in
//   flush   : flush_valid_i/vpn/asid/any_vpn/any_asid -> flush_done_o (next cycle)
//   PMU     : pmu_access_o, pmu_miss_o (registered pulses) - present only when
//             PARAM_TLB_PMU_EN is defined, otherwise tied low.
//
// state                     | meaning
// IDLE                      | accepting lookups, ready_o=1
// SEND_REQUEST              | walk request presented to the PTW
// WAIT_RESPONSE             | walk accepted, response will fill the victim
// INVALIDATED_WAIT_RESPONSE | flushed during the walk, response is dropped
module param_tlb
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  input  logic [27:0]       req_vpn_i,
  input  logic [ASID_W-1:0] req_asid_i,
  input  logic              req_store_i,
  input  logic              req_fetch_i,
  input  logic              req_passthrough_i,
  input  logic              vm_enable_i,
  input  logic [1:0]        priv_lvl_i,
  input  logic              sum_i,
  input  logic              mxr_i,
  output logic              ready_o,
  output logic              miss_o,
  output logic [43:0]       ppn_o,
  output logic              xcpt_ld_o,
  output logic              xcpt_st_o,
  output logic              xcpt_if_o,
  output logic              ptw_req_valid_o,
  output logic [26:0]       ptw_req_vpn_o,
  output logic [ASID_W-1:0] ptw_req_asid_o,
  output logic              ptw_req_store_o,
  output logic              ptw_req_fetch_o,
  input  logic              ptw_ready_i,
  input  logic              ptw_resp_valid_i,
  input  pte_t              ptw_resp_pte_i,
  input  logic [1:0]        ptw_resp_level_i,
  input  logic              ptw_resp_error_i,
  input  logic              flush_valid_i,
  input  logic [26:0]       flush_vpn_i,
  input  logic [ASID_W-1:0] flush_asid_i,
  input  logic              flush_any_vpn_i,
  input  logic              flush_any_asid_i,
  output logic              flush_done_o,
  output logic              pmu_access_o,
  output logic              pmu_miss_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    IDLE, SEND_REQUEST, WAIT_RESPONSE, INVALIDATED_WAIT_RESPONSE
  } state_e;

  state_e            state_q, state_d;
  param_tlb_entry_t  entry_q [ENTRIES];
  logic [ASID_W-1:0] asid_q  [ENTRIES];

  logic [26:0]       lat_vpn_q;
  logic [ASID_W-1:0] lat_asid_q;
  logic              lat_store_q, lat_fetch_q, lat_en;
  logic [IDX_W-1:0]  lat_victim_q, plru_victim;

  logic [ENTRIES-1:0] hit_vec, flush_hit;
  logic               hit, have_empty, bad_va, idle_req;
  logic [IDX_W-1:0]   hit_idx, empty_idx;
  param_tlb_entry_t   hit_e, fill_e;
  logic               r_ok, w_ok, x_ok, r_bit, store_ok, clean_clr, fill_we;
  logic               flush_done_q, unused_pte;

  assign idle_req = req_valid_i && (state_q == IDLE);
  assign bad_va   = req_vpn_i[27] != req_vpn_i[26];

  always_comb begin
    hit_vec    = '0;
    flush_hit  = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    have_empty = 1'b0;
    empty_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = entry_q[i].nempty && (asid_q[i] == req_asid_i || entry_q[i].g) &&
                   vpn_match(entry_q[i].level, entry_q[i].vpn, req_vpn_i[26:0]);
      flush_hit[i] = flush_valid_i &&
                     (flush_any_vpn_i || vpn_match(entry_q[i].level, entry_q[i].vpn, flush_vpn_i)) &&
                     (flush_any_asid_i || (asid_q[i] == flush_asid_i && !entry_q[i].g));
    end
    // Descending scan leaves the lowest matching index selected.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entry_q[i].nempty) begin
        have_empty = 1'b1;
        empty_idx  = IDX_W'(i);
      end
    end
  end

  assign hit_e = entry_q[hit_idx];

  // An error fill (valid=0) fails every permission, so it faults instead of missing.
  always_comb begin
    r_bit = hit_e.r || (mxr_i && hit_e.x);
    if (priv_lvl_i == 2'd0) begin
      r_ok = hit_e.u && r_bit;
      w_ok = hit_e.u && hit_e.w;
      x_ok = hit_e.u && hit_e.x;
    end else begin
      r_ok = (!hit_e.u || sum_i) && r_bit;
      w_ok = (!hit_e.u || sum_i) && hit_e.w;
      x_ok = !hit_e.u && hit_e.x;
    end
    r_ok = r_ok && hit_e.valid;
    w_ok = w_ok && hit_e.valid;
    x_ok = x_ok && hit_e.valid;
  end

  // A clean writable page needs the walker to set D, so the store re-walks.
  assign store_ok  = !req_store_i || hit_e.d || !w_ok;
  assign clean_clr = idle_req && hit && !store_ok;
  assign miss_o    = vm_enable_i && !bad_va && !(hit && store_ok);
  assign xcpt_ld_o = bad_va || (hit && !r_ok);
  assign xcpt_st_o = bad_va || (hit && !w_ok);
  assign xcpt_if_o = bad_va || (hit && !x_ok);

  always_comb begin
    ppn_o = '0;
    if (!vm_enable_i || req_passthrough_i) begin
      ppn_o = {17'd0, req_vpn_i[26:0]};
    end else if (hit) begin
      case (hit_e.level)
        MEGA_PAGE: ppn_o = {hit_e.ppn[43:9], req_vpn_i[8:0]};
        GIGA_PAGE: ppn_o = {hit_e.ppn[43:18], req_vpn_i[17:0]};
        default:   ppn_o = hit_e.ppn;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    lat_en  = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i && miss_o) begin
        state_d = SEND_REQUEST;
        lat_en  = 1'b1;
      end
      SEND_REQUEST: begin
        if (ptw_ready_i)        state_d = flush_valid_i ? INVALIDATED_WAIT_RESPONSE : WAIT_RESPONSE;
        else if (flush_valid_i) state_d = IDLE;
      end
      WAIT_RESPONSE: begin
        if (ptw_resp_valid_i)   state_d = IDLE;
        else if (flush_valid_i) state_d = INVALIDATED_WAIT_RESPONSE;
      end
      default: if (ptw_resp_valid_i) state_d = IDLE;
    endcase
  end

  // A flush coinciding with the response drops the fill: the walk may be stale.
  assign fill_we = (state_q == WAIT_RESPONSE) && ptw_resp_valid_i && !flush_valid_i;

  always_comb begin
    fill_e        = '0;
    fill_e.nempty = 1'b1;
    fill_e.valid  = !ptw_resp_error_i;
    fill_e.level  = pg_level_e'(ptw_resp_level_i);
    fill_e.vpn    = lat_vpn_q;
    fill_e.ppn    = ptw_resp_pte_i.ppn;
    fill_e.d      = ptw_resp_pte_i.d;
    fill_e.g      = ptw_resp_pte_i.g;
    fill_e.u      = ptw_resp_pte_i.u;
    fill_e.x      = ptw_resp_pte_i.x;
    fill_e.w      = ptw_resp_pte_i.w;
    fill_e.r      = ptw_resp_pte_i.r;
  end

  assign unused_pte = ^{ptw_resp_pte_i.reserved, ptw_resp_pte_i.rsw,
                        ptw_resp_pte_i.a, ptw_resp_pte_i.v};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
        asid_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_hit[i]) begin
          entry_q[i] <= '0;
        end else if (fill_we && lat_victim_q == IDX_W'(i)) begin
          entry_q[i] <= fill_e;
          asid_q[i]  <= lat_asid_q;
        end else if (clean_clr && hit_idx == IDX_W'(i)) begin
          entry_q[i] <= '0;
        end else if (idle_req && !entry_q[i].valid) begin
          entry_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      lat_vpn_q    <= '0;
      lat_asid_q   <= '0;
      lat_store_q  <= 1'b0;
      lat_fetch_q  <= 1'b0;
      lat_victim_q <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_valid_i;
      if (lat_en) begin
        lat_vpn_q    <= req_vpn_i[26:0];
        lat_asid_q   <= req_asid_i;
        lat_store_q  <= req_store_i;
        lat_fetch_q  <= req_fetch_i;
        lat_victim_q <= have_empty ? empty_idx : plru_victim;
      end
    end
  end

  param_tlb_plru #(.ENTRIES(ENTRIES)) u_plru (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .touch_i     (idle_req && hit),
    .touch_idx_i (hit_idx),
    .victim_o    (plru_victim)
  );

  assign ready_o         = state_q == IDLE;
  assign ptw_req_valid_o = state_q == SEND_REQUEST;
  assign ptw_req_vpn_o   = lat_vpn_q;
  assign ptw_req_asid_o  = lat_asid_q;
  assign ptw_req_store_o = lat_store_q;
  assign ptw_req_fetch_o = lat_fetch_q;
  assign flush_done_o    = flush_done_q;

`ifdef PARAM_TLB_PMU_EN
  logic pmu_access_q, pmu_miss_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pmu_access_q <= 1'b0;
      pmu_miss_q   <= 1'b0;
    end else begin
      pmu_access_q <= idle_req;
      pmu_miss_q   <= idle_req && miss_o;
    end
  end
  assign pmu_access_o = pmu_access_q;
  assign pmu_miss_o   = pmu_miss_q;
`else
  assign pmu_access_o = 1'b0;
  assign pmu_miss_o   = 1'b0;
`endif

endmodule

// File: tb/tb_param_tlb.sv
// tb_param_tlb: directed self-checking bench for param_tlb (default build,
// ENTRIES=16, ASID_W=16, PMU disabled).
module tb_param_tlb;
  import mmu_pkg::*;

  localparam int ENTRIES = 16;
  localparam int ASID_W  = 16;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              req_valid_i, req_store_i, req_fetch_i, req_passthrough_i;
  logic [27:0]       req_vpn_i;
  logic [ASID_W-1:0] req_asid_i;
  logic              vm_enable_i, sum_i, mxr_i;
  logic [1:0]        priv_lvl_i;
  logic              ready_o, miss_o, xcpt_ld_o, xcpt_st_o, xcpt_if_o;
  logic [43:0]       ppn_o;
  logic              ptw_req_valid_o, ptw_req_store_o, ptw_req_fetch_o, ptw_ready_i;
  logic [26:0]       ptw_req_vpn_o;
  logic [ASID_W-1:0] ptw_req_asid_o;
  logic              ptw_resp_valid_i, ptw_resp_error_i;
  pte_t              ptw_resp_pte_i;
  logic [1:0]        ptw_resp_level_i;
  logic              flush_valid_i, flush_any_vpn_i, flush_any_asid_i, flush_done_o;
  logic [26:0]       flush_vpn_i;
  logic [ASID_W-1:0] flush_asid_i;
  logic              pmu_access_o, pmu_miss_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  param_tlb #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_vpn_i(req_vpn_i), .req_asid_i(req_asid_i),
    .req_store_i(req_store_i), .req_fetch_i(req_fetch_i), .req_passthrough_i(req_passthrough_i),
    .vm_enable_i(vm_enable_i), .priv_lvl_i(priv_lvl_i), .sum_i(sum_i), .mxr_i(mxr_i),
    .ready_o(ready_o), .miss_o(miss_o), .ppn_o(ppn_o),
    .xcpt_ld_o(xcpt_ld_o), .xcpt_st_o(xcpt_st_o), .xcpt_if_o(xcpt_if_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
    .ptw_req_store_o(ptw_req_store_o), .ptw_req_fetch_o(ptw_req_fetch_o), .ptw_ready_i(ptw_ready_i),
    .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_pte_i(ptw_resp_pte_i),
    .ptw_resp_level_i(ptw_resp_level_i), .ptw_resp_error_i(ptw_resp_error_i),
    .flush_valid_i(flush_valid_i), .flush_vpn_i(flush_vpn_i), .flush_asid_i(flush_asid_i),
    .flush_any_vpn_i(flush_any_vpn_i), .flush_any_asid_i(flush_any_asid_i), .flush_done_o(flush_done_o),
    .pmu_access_o(pmu_access_o), .pmu_miss_o(pmu_miss_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic pte_t mk_pte(input logic [43:0] ppn, input logic u, input logic x,
                                  input logic w, input logic r, input logic d, input logic g);
    pte_t p;
    p = '0;
    p.ppn = ppn; p.u = u; p.x = x; p.w = w; p.r = r; p.d = d; p.g = g;
    p.a = 1'b1; p.v = 1'b1;
    return p;
  endfunction

  // Combinational probe: req_valid_i stays low so nothing in the TLB changes.
  task automatic lookup(input logic [27:0] vpn, input logic [15:0] asid, input logic store);
    req_valid_i = 1'b0;
    req_vpn_i   = vpn;
    req_asid_i  = asid;
    req_store_i = store;
    #1;
  endtask

  task automatic do_flush(input logic [26:0] vpn, input logic [15:0] asid,
                          input logic any_vpn, input logic any_asid);
    flush_valid_i = 1'b1; flush_vpn_i = vpn; flush_asid_i = asid;
    flush_any_vpn_i = any_vpn; flush_any_asid_i = any_asid;
    tick();
    flush_valid_i = 1'b0; flush_any_vpn_i = 1'b0; flush_any_asid_i = 1'b0;
  endtask

  task automatic fill(input logic [27:0] vpn, input logic [15:0] asid, input pte_t pte,
                      input logic [1:0] level, input logic err);
    req_valid_i = 1'b1; req_vpn_i = vpn; req_asid_i = asid; req_store_i = 1'b0;
    #1;
    check("fill_miss", miss_o, 1);
    tick();
    req_valid_i = 1'b0;
    ptw_ready_i = 1'b1;
    tick();
    ptw_ready_i = 1'b0;
    ptw_resp_valid_i = 1'b1; ptw_resp_pte_i = pte; ptw_resp_level_i = level; ptw_resp_error_i = err;
    tick();
    ptw_resp_valid_i = 1'b0; ptw_resp_error_i = 1'b0;
    check("fill_ready", ready_o, 1);
  endtask

  initial begin
    req_valid_i = 0; req_vpn_i = 0; req_asid_i = 1; req_store_i = 0; req_fetch_i = 0;
    req_passthrough_i = 0; vm_enable_i = 1; priv_lvl_i = 2'd1; sum_i = 0; mxr_i = 0;
    ptw_ready_i = 0; ptw_resp_valid_i = 0; ptw_resp_pte_i = '0; ptw_resp_level_i = 0;
    ptw_resp_error_i = 0; flush_valid_i = 0; flush_vpn_i = 0; flush_asid_i = 0;
    flush_any_vpn_i = 0; flush_any_asid_i = 0;

    // reset values
    #12;
    check("rst_ready", ready_o, 1);
    check("rst_ptw_valid", ptw_req_valid_o, 0);
    check("rst_ptw_vpn", ptw_req_vpn_o, 0);
    check("rst_flush_done", flush_done_o, 0);
    check("rst_pmu", {pmu_access_o, pmu_miss_o}, 0);
    @(negedge clk_i); rstn_i = 1'b1;
    tick();
    lookup(28'h1234, 1, 0);
    check("empty_miss", miss_o, 1);
    check("empty_ppn", ppn_o, 0);

    // kilo miss then fill
    req_valid_i = 1; req_vpn_i = 28'h1234; #1;
    check("k_miss", miss_o, 1);
    tick();
    req_valid_i = 0;
    check("k_ptw_valid", ptw_req_valid_o, 1);
    check("k_ptw_vpn", ptw_req_vpn_o, 27'h1234);
    check("k_ready_busy", ready_o, 0);
    ptw_ready_i = 1; tick(); ptw_ready_i = 0;
    ptw_resp_valid_i = 1; ptw_resp_pte_i = mk_pte(44'hABCDE, 0, 0, 1, 1, 1, 0);
    ptw_resp_level_i = KILO_PAGE; tick(); ptw_resp_valid_i = 0;
    lookup(28'h1234, 1, 0);
    check("k_hit_miss", miss_o, 0);
    check("k_hit_ppn", ppn_o, 44'hABCDE);
    check("k_hit_xld", xcpt_ld_o, 0);

    // giga and mega fills
    fill(28'h0040000, 1, mk_pte(44'h40000, 0, 0, 1, 1, 1, 0), GIGA_PAGE, 0);
    lookup(28'h0040123, 1, 0);
    check("g_miss", miss_o, 0);
    check("g_ppn", ppn_o, 44'h40123);
    fill(28'h0600200, 1, mk_pte(44'hABC00, 0, 0, 1, 1, 1, 0), MEGA_PAGE, 0);
    lookup(28'h06002FF, 1, 0);
    check("m_ppn", ppn_o, 44'hABCFF);

    // translation off / passthrough / bad VA
    vm_enable_i = 0; lookup(28'h1234567, 1, 0);
    check("vmoff_ppn", ppn_o, 44'h1234567);
    check("vmoff_miss", miss_o, 0);
    vm_enable_i = 1; req_passthrough_i = 1; lookup(28'h1234, 1, 0);
    check("pass_ppn", ppn_o, 44'h1234);
    req_passthrough_i = 0;
    lookup(28'h8000000, 1, 0);
    check("badva_x", {xcpt_ld_o, xcpt_st_o, xcpt_if_o}, 3'b111);
    check("badva_miss", miss_o, 0);

    // permissions
    fill(28'h4000, 1, mk_pte(44'h444, 1, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    lookup(28'h4000, 1, 1);
    check("s_user_st_x", xcpt_st_o, 1);
    check("s_user_st_miss", miss_o, 0);
    sum_i = 1; #1;
    check("s_sum_st_x", xcpt_st_o, 0);
    sum_i = 0; priv_lvl_i = 0; #1;
    check("u_st_x", xcpt_st_o, 0);
    check("u_if_x", xcpt_if_o, 1);
    priv_lvl_i = 1;
    fill(28'h4001, 1, mk_pte(44'h445, 0, 1, 0, 0, 1, 0), KILO_PAGE, 0);
    lookup(28'h4001, 1, 0);
    check("xonly_ld_x", xcpt_ld_o, 1);
    mxr_i = 1; #1;
    check("mxr_ld_x", xcpt_ld_o, 0);
    mxr_i = 0;

    // clean-store clear; walk cancelled by a non-matching flush
    fill(28'h5000, 1, mk_pte(44'h555, 0, 0, 1, 1, 0, 0), KILO_PAGE, 0);
    lookup(28'h5000, 1, 1);
    check("clean_st_miss", miss_o, 1);
    req_store_i = 0; #1;
    check("clean_ld_hit", miss_o, 0);
    req_valid_i = 1; req_store_i = 1; #1;
    tick();
    req_valid_i = 0; req_store_i = 0;
    do_flush(27'h7FFFFFF, 16'hFFFF, 0, 0);
    #1;
    check("cancel_ready", ready_o, 1);
    check("cancel_fdone", flush_done_o, 1);
    lookup(28'h5000, 1, 0);
    check("clean_cleared", miss_o, 1);

    // error fill faults once, then is dropped
    fill(28'h6000, 1, mk_pte(44'h666, 0, 0, 1, 1, 1, 0), KILO_PAGE, 1);
    lookup(28'h6000, 1, 0);
    check("err_miss", miss_o, 0);
    check("err_xld", xcpt_ld_o, 1);
    req_valid_i = 1; #1;
    tick();
    req_valid_i = 0;
    check("err_no_walk", ready_o, 1);
    check("pmu_off", pmu_access_o, 0);
    lookup(28'h6000, 1, 0);
    check("err_dropped", miss_o, 1);

    // flush during WAIT_RESPONSE
    req_valid_i = 1; req_vpn_i = 28'h2000; #1;
    tick();
    req_valid_i = 0; ptw_ready_i = 1;
    tick();
    ptw_ready_i = 0;
    do_flush(27'h7FFFFFF, 16'hFFFF, 0, 0);
    #1;
    check("inv_busy", ready_o, 0);
    check("inv_fdone", flush_done_o, 1);
    ptw_resp_valid_i = 1; ptw_resp_pte_i = mk_pte(44'h777, 0, 0, 1, 1, 1, 0);
    ptw_resp_level_i = KILO_PAGE; tick(); ptw_resp_valid_i = 0;
    check("inv_ready", ready_o, 1);
    lookup(28'h2000, 1, 0);
    check("inv_no_write", miss_o, 1);

    // ASID flush
    fill(28'h3000, 5, mk_pte(44'h300, 0, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    fill(28'h3001, 5, mk_pte(44'h301, 0, 0, 1, 1, 1, 1), KILO_PAGE, 0);
    fill(28'h3002, 6, mk_pte(44'h302, 0, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    fill(28'h3003, 5, mk_pte(44'h303, 0, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    flush_valid_i = 1; flush_any_vpn_i = 1; flush_asid_i = 5; #1;
    check("af_fdone_now", flush_done_o, 0);
    tick();
    flush_valid_i = 0; flush_any_vpn_i = 0;
    check("af_fdone", flush_done_o, 1);
    lookup(28'h3000, 5, 0); check("af_a5", miss_o, 1);
    lookup(28'h3001, 5, 0); check("af_glob", miss_o, 0);
    lookup(28'h3002, 6, 0); check("af_a6", miss_o, 0);
    lookup(28'h3003, 5, 0); check("af_a5b", miss_o, 1);
    tick();
    check("af_fdone_pulse", flush_done_o, 0);

    // reset mid-walk, late response ignored
    req_valid_i = 1; req_vpn_i = 28'h300; req_asid_i = 1; #1;
    tick();
    req_valid_i = 0; ptw_ready_i = 1;
    tick();
    ptw_ready_i = 0; rstn_i = 0; #1;
    check("mw_rst_ready", ready_o, 1);
    check("mw_rst_ptw", ptw_req_valid_o, 0);
    @(negedge clk_i); rstn_i = 1;
    tick();
    ptw_resp_valid_i = 1; ptw_resp_pte_i = mk_pte(44'h333, 0, 0, 1, 1, 1, 0); tick();
    ptw_resp_valid_i = 0;
    lookup(28'h300, 1, 0); check("mw_ignored", miss_o, 1);
    lookup(28'h1234, 1, 0); check("mw_cleared", miss_o, 1);

    // capacity: touch way 0, so the tree victim becomes way 8
    for (int i = 0; i < ENTRIES; i++)
      fill(28'h100 + 28'(i), 1, mk_pte(44'h900 + 44'(i), 0, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    req_valid_i = 1; req_vpn_i = 28'h100; #1;
    check("cap_touch_hit", miss_o, 0);
    tick();
    req_valid_i = 0;
    fill(28'h200, 1, mk_pte(44'hA00, 0, 0, 1, 1, 1, 0), KILO_PAGE, 0);
    lookup(28'h108, 1, 0); check("cap_evicted", miss_o, 1);
    for (int i = 0; i < ENTRIES; i++) begin
      if (i != 8) begin
        lookup(28'h100 + 28'(i), 1, 0);
        check("cap_keep", {miss_o, ppn_o}, {1'b0, 44'h900 + 44'(i)});
      end
    end
    lookup(28'h200, 1, 0); check("cap_new", ppn_o, 44'hA00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_tlb.md
PARAM_TLB -- requirements
Module: param_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of fully associative entries (power of 2, 2..64).
REQ-002 SHALL have parameter ASID_W, default 16, ASID width in bits.
REQ-003 SHALL have port clk_i  in  1  the single clock.
REQ-004 SHALL have port rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have these request ports: req_valid_i in 1; req_vpn_i in 28 (bit 27 = sign copy); req_asid_i in ASID_W; req_store_i in 1; req_fetch_i in 1; req_passthrough_i in 1.
REQ-006 SHALL have these status ports: vm_enable_i in 1; priv_lvl_i in 2 (0 = user); sum_i in 1; mxr_i in 1.
REQ-007 SHALL have these response ports: ready_o out 1; miss_o out 1; ppn_o out 44; xcpt_ld_o out 1; xcpt_st_o out 1; xcpt_if_o out 1.
REQ-008 SHALL have these PTW request ports: ptw_req_valid_o out 1; ptw_req_vpn_o out 27; ptw_req_asid_o out ASID_W; ptw_req_store_o out 1; ptw_req_fetch_o out 1; ptw_ready_i in 1.
REQ-009 SHALL have these PTW response ports: ptw_resp_valid_i in 1; ptw_resp_pte_i in pte_t; ptw_resp_level_i in 2; ptw_resp_error_i in 1.
REQ-010 SHALL have these flush ports: flush_valid_i in 1; flush_vpn_i in 27; flush_asid_i in ASID_W; flush_any_vpn_i in 1; flush_any_asid_i in 1; flush_done_o out 1.
REQ-011 SHALL have these PMU ports: pmu_access_o out 1; pmu_miss_o out 1.

Function
REQ-012 Lookup SHALL be combinational, with zero-cycle hit latency. An entry hits when all of the following hold: it is non-empty; (asid matches OR entry.g); and the VPN matches at the entry's level (giga: bits 26:18; mega: bits 26:9; kilo: bits 26:0).
REQ-013 ppn_o SHALL select by case:
- kilo hit: entry ppn;
- mega hit: ppn[43:9] concatenated with vpn[8:0];
- giga hit: ppn[43:18] concatenated with vpn[17:0];
- vm_enable_i=0 or passthrough: zero-extended req_vpn_i[26:0];
- no hit: 0.
REQ-014 bad_va SHALL be asserted when req_vpn_i[27] != req_vpn_i[26]. Each of the three xcpt outputs = bad_va OR (hit AND its permission fails).
REQ-015 Permissions SHALL be checked as follows:
- User mode: user bits only.
- Supervisor mode: supervisor bits; add user r/w bits if sum_i=1.
- mxr_i=1: execute-permitted counts as readable.
REQ-016 miss_o SHALL equal vm_enable_i AND NOT bad_va AND NOT (hit AND store_ok). store_ok = NOT store OR dirty OR NOT write_ok.
REQ-017 A store that hits a clean, writable entry SHALL clear that entry in the same cycle and SHALL be treated as a miss.
REQ-018 The FSM SHALL have states IDLE, SEND_REQUEST, WAIT_RESPONSE and INVALIDATED_WAIT_RESPONSE. ready_o SHALL be 1 only in IDLE.
REQ-019 In IDLE, req_valid_i AND miss_o SHALL latch vpn, asid, store, fetch and victim index, and move to SEND_REQUEST.
REQ-020 In SEND_REQUEST, ptw_req_valid_o SHALL be 1 and the other ptw_req_* outputs SHALL be driven from the latch. Transitions:
- ptw_ready_i=1: go to WAIT_RESPONSE, or to INVALIDATED_WAIT_RESPONSE if a flush occurs in the same cycle.
- flush while ptw_ready_i=0: go to IDLE (request cancelled).
REQ-021 In WAIT_RESPONSE, ptw_resp_valid_i SHALL write the victim entry, with valid = NOT error, and return to IDLE. A flush without a response SHALL move to INVALIDATED_WAIT_RESPONSE.
REQ-022 INVALIDATED_WAIT_RESPONSE SHALL discard the response and return to IDLE.
REQ-023 The victim SHALL be the lowest-index empty entry; if no entry is empty, the PLRU choice.
REQ-024 The PLRU SHALL be updated on every req_valid_i hit in IDLE.
REQ-025 A flush SHALL be accepted in any state and take effect in one cycle. flush_done_o SHALL pulse for 1 cycle on the following cycle.
REQ-026 A flush SHALL clear an entry when (flush_any_vpn_i OR VPN match at the entry's level) AND (flush_any_asid_i OR (asid match AND NOT entry.g)).
REQ-027 Flush SHALL take priority over a PTW write and over the clean-store clear in the same cycle.
REQ-028 Entries with valid=0 SHALL be cleared on the next req_valid_i in IDLE.
REQ-029 pmu_access_o SHALL pulse on req_valid_i in IDLE. pmu_miss_o SHALL pulse when that request also misses.

Reset
REQ-030 On reset, all entries, the latch and the PLRU SHALL be cleared, and the state SHALL be IDLE.
REQ-031 Output values during reset SHALL be: ptw_req_* = 0; flush_done_o = 0; pmu_* = 0; ready_o = 1.
REQ-032 A reset asserted mid-walk SHALL abandon the walk, and a later ptw_resp_valid_i received in IDLE SHALL be ignored.

Configuration
REQ-033 With macro PARAM_TLB_PMU_EN defined, pmu_access_o and pmu_miss_o SHALL behave per REQ-029.
REQ-034 With PARAM_TLB_PMU_EN undefined, pmu_access_o and pmu_miss_o SHALL be tied to 0 and no PMU logic SHALL be synthesised.

Structure
REQ-035 mmu_pkg SHALL hold pte_t, the level enum (KILO_PAGE/MEGA_PAGE/GIGA_PAGE), VPN_SIZE, PPN_SIZE, PAGE_LVL_BITS, and a param_tlb_entry_t that includes a g bit.
REQ-036 The existing pseudoLRU, parametrised by ENTRIES, SHALL be the only sub-module.

Verification
REQ-037 Kilo-page miss then fill: miss_o=1 and ptw_req_vpn_o=0x1234 one cycle later. The PTW returns ppn 0xABCDE at level kilo. A repeat request then gives miss_o=0 and ppn_o=0xABCDE.
REQ-038 Giga-page fill: ppn 0x40000 at level giga, then vpn 0x0040123 gives ppn_o=0x40123.
REQ-039 Flush while in WAIT_RESPONSE: the state goes to INVALIDATED_WAIT_RESPONSE, the response causes no write, and the next identical request misses again.
REQ-040 ASID flush with flush_asid_i=5: non-global ASID-5 entries are cleared, the global entry and ASID-6 entries survive, and flush_done_o=1 one cycle later.
REQ-041 Supervisor store with sum_i=0 to a user page that is writable and dirty: xcpt_st_o=1 and miss_o=0.
REQ-042 Capacity: fill ENTRIES+1 distinct pages. The last fill evicts the PLRU victim, and all other entries still hit.
